bcd_score_counter: RTL and testbench
====================================

# bcd_score_counter

Parametrised multi-digit BCD score counter with high-score tracking. It replaces per-digit up-counter chains in the game datapath. It accepts single-digit add and subtract requests while a game is running, saturates at the all-nines maximum and floors at zero. When a game ends it latches a high score and pulses a new-record flag. Its outputs feed the seven-segment display mux directly as packed BCD.

## Interface
- DIGITS, default 4: number of BCD digits; legal range 1–8.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- gaming  in  1  high while a game is in progress; add and subtract are honoured only when it is high.
- clear  in  1  synchronous clear of score and overflow; works whether or not gaming is high.
- add_valid  in  1  add request for the current cycle.
- add_amt  in  4  amount to add, 0–9; values 10–15 are clamped to 9.
- sub_valid  in  1  subtract (penalty) request for the current cycle.
- sub_amt  in  4  amount to subtract, 0–9; values 10–15 are clamped to 9.
- score  out  4*DIGITS  current score, packed BCD; digit 0 is bits [3:0].
- hi_score  out  4*DIGITS  best score of completed games, packed BCD.
- overflow  out  1  sticky flag; set when an add saturates.
- new_record  out  1  one-cycle pulse when hi_score is updated.

## Operation
- Reset values: score=0, hi_score=0, overflow=0, new_record=0, internal gaming_d=0.
- Per-edge priority for score:
  1. clear: score←0 and overflow←0.
  2. gaming && add_valid: add is applied.
  3. gaming && sub_valid: subtract is applied.
  4. Otherwise score holds.
- Add and subtract asserted together: add wins, subtract is dropped for that cycle.
- Add rule:
  - Clamped amount is added to digit 0; decimal carries ripple through all DIGITS in the same cycle.
  - Every digit stays 0–9 after the operation.
  - If the true sum exceeds 10^DIGITS−1, score←all nines and overflow←1.
- Subtract rule:
  - Clamped amount is subtracted with decimal borrow ripple.
  - If the result would be negative, score←0; overflow is unaffected.
- overflow stays 1 until clear or rst; further saturating adds keep it at 1.
- End of game:
  - gaming_d is gaming registered every edge; end_game = gaming_d && !gaming.
  - On an edge where end_game=1 and score > hi_score (unsigned compare of the packed BCD, which preserves magnitude): hi_score←score and new_record←1.
  - Otherwise new_record←0.
- clear in the end_game cycle: hi_score captures the pre-clear score.
- hi_score is never altered by clear, only by rst.
- Inputs are sampled only at clock edges. Digits arriving at 10–15 cannot occur, because only reset and the rules above write score.

## Timing
- score, overflow: visible one cycle after the request edge; back-to-back requests every cycle are accumulated.
- hi_score, new_record: registered at the first edge where gaming is sampled low after being high. new_record is high for exactly that one cycle.
- Rising edge of gaming has no side effects.
- rst mid-operation: all outputs go to reset values immediately, independent of clk. The first request after rst deasserts is honoured normally.
- Combinational path: the add/subtract carry chain is DIGITS deep; DIGITS ≤ 8 must meet the 100 MHz clock.

## Test plan
All scenarios use DIGITS=4.
- Reset, then gaming=1 with add_valid for 3 cycles at add_amt=7 -> score 0x0007, 0x0014, 0x0021; overflow=0.
- score=0x0999, add 5 -> 0x1004 (ripple across three digits). Then add_amt=12 -> clamped to 9, score 0x1013.
- score=0x9995, add 9 -> score 0x9999 and overflow=1. Then clear -> score 0x0000, overflow=0.
- score=0x0003, sub 8 -> 0x0000. score=0x0100, sub 1 -> 0x0099. Add 4 and sub 2 in the same cycle -> only +4 applied.
- gaming=0 with add_valid -> score unchanged. With clear=1 and gaming=0 -> score clears.
- End of game:
  - Game ends at score 0x0250 with hi_score 0 -> hi_score 0x0250 and a single-cycle new_record.
  - Next game ends at 0x0120 -> no update, no pulse.
  - clear in the end cycle at 0x0300 -> hi_score 0x0300 and score 0.
  - Async rst mid-game -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: multi-digit BCD score counter with saturation, floor at zero and high-score capture
//   clk, rst                 clock, asynchronous active-high reset
//   gaming_i                 game in progress; gates add/sub, falling edge ends a game
//   clear_i                  synchronous clear of score and overflow
//   add_valid_i, add_amt_i   add request, amount 0-9 (10-15 clamped to 9)
//   sub_valid_i, sub_amt_i   subtract request, amount 0-9 (10-15 clamped to 9)
//   score_o, hi_score_o      packed BCD, digit 0 in bits [3:0]
//   overflow_o               sticky, set by a saturating add
//   new_record_o             one-cycle pulse when hi_score_o updates
module bcd_score_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gaming_i,
  input  logic                  clear_i,
  input  logic                  add_valid_i,
  input  logic [3:0]            add_amt_i,
  input  logic                  sub_valid_i,
  input  logic [3:0]            sub_amt_i,
  output logic [4*DIGITS-1:0]   score_o,
  output logic [4*DIGITS-1:0]   hi_score_o,
  output logic                  overflow_o,
  output logic                  new_record_o
);
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};
  logic [4*DIGITS-1:0] score_q, score_d, hi_q, hi_d, add_res, sub_res;
  logic                ovf_q, ovf_d, rec_q, rec_d, gaming_q;
  logic                add_c, sub_b, do_add, do_sub, end_game;
  logic [3:0]          a_amt, s_amt;
  logic [4:0]          ad, sd;
  assign a_amt = add_amt_i > 4'd9 ? 4'd9 : add_amt_i;
  assign s_amt = sub_amt_i > 4'd9 ? 4'd9 : sub_amt_i;
  // Decimal ripple: digit 0 takes the amount, higher digits take the carry/borrow.
  // A carry out of the top digit means saturation; a borrow out means the floor at zero.
  always_comb begin
    add_c   = 1'b0;
    sub_b   = 1'b0;
    ad      = '0;
    sd      = '0;
    add_res = '0;
    sub_res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ad = {1'b0, score_q[4*i+:4]} + (i == 0 ? {1'b0, a_amt} : {4'b0, add_c});
      sd = {1'b0, score_q[4*i+:4]} - (i == 0 ? {1'b0, s_amt} : {4'b0, sub_b});
      add_c = ad > 5'd9;
      sub_b = sd[4];
      add_res[4*i+:4] = add_c ? ad[3:0] - 4'd10 : ad[3:0];
      sub_res[4*i+:4] = sub_b ? sd[3:0] + 4'd10 : sd[3:0];
    end
  end
  assign do_add   = gaming_i && add_valid_i;
  assign do_sub   = gaming_i && sub_valid_i && !add_valid_i;
  assign end_game = gaming_q && !gaming_i;
  always_comb begin
    score_d = clear_i ? '0 :
              do_add  ? (add_c ? NINES : add_res) :
              do_sub  ? (sub_b ? '0 : sub_res) : score_q;
    ovf_d   = clear_i ? 1'b0 : (do_add && add_c) || ovf_q;
    // Packed BCD compares correctly as unsigned binary; the pre-clear score is captured.
    rec_d   = end_game && (score_q > hi_q);
    hi_d    = rec_d ? score_q : hi_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q  <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
      rec_q    <= 1'b0;
      gaming_q <= 1'b0;
    end else begin
      score_q  <= score_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
      rec_q    <= rec_d;
      gaming_q <= gaming_i;
    end
  end
  assign score_o      = score_q;
  assign hi_score_o   = hi_q;
  assign overflow_o   = ovf_q;
  assign new_record_o = rec_q;
endmodule

// File: tb/tb_bcd_score_counter.sv
// tb_bcd_score_counter: directed self-checking bench for bcd_score_counter (DIGITS=4)
module tb_bcd_score_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        gaming = 1'b0, clear = 1'b0, add_valid = 1'b0, sub_valid = 1'b0;
  logic [3:0]  add_amt = '0, sub_amt = '0;
  logic [15:0] score, hi_score;
  logic        overflow, new_record;
  int          n_cmp = 0;
  int          n_bad = 0;

  bcd_score_counter #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .gaming_i(gaming), .clear_i(clear),
    .add_valid_i(add_valid), .add_amt_i(add_amt),
    .sub_valid_i(sub_valid), .sub_amt_i(sub_amt),
    .score_o(score), .hi_score_o(hi_score),
    .overflow_o(overflow), .new_record_o(new_record)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_score(input string name, input logic [15:0] exp);
    n_cmp++;
    if (score !== exp) begin
      n_bad++;
      $display("FAIL %s score=%h expected=%h", name, score, exp);
    end
  endtask

  task automatic chk_ovf(input string name, input logic exp);
    n_cmp++;
    if (overflow !== exp) begin
      n_bad++;
      $display("FAIL %s overflow=%b expected=%b", name, overflow, exp);
    end
  endtask

  task automatic chk_hi(input string name, input logic [15:0] exp_hi, input logic exp_nr);
    n_cmp++;
    if (hi_score !== exp_hi) begin
      n_bad++;
      $display("FAIL %s hi_score=%h expected=%h", name, hi_score, exp_hi);
    end
    n_cmp++;
    if (new_record !== exp_nr) begin
      n_bad++;
      $display("FAIL %s new_record=%b expected=%b", name, new_record, exp_nr);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    gaming = 1'b0; clear = 1'b0; add_valid = 1'b0; sub_valid = 1'b0;
    #1;
    tick();
    rst = 1'b0;
  endtask

  // Clear, then reach decimal value v by a run of adds of at most 9 while gaming.
  task automatic set_score(input int v);
    int r;
    r = v;
    gaming = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; add_valid = 1'b1;
    while (r > 0) begin
      add_amt = (r > 9) ? 4'd9 : 4'(r);
      r -= int'(add_amt);
      tick();
    end
    add_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_score("reset", 16'h0000);
    chk_ovf("reset", 1'b0);
    chk_hi("reset", 16'h0000, 1'b0);
  endtask

  task automatic test_add();
    gaming = 1'b1; add_valid = 1'b1; add_amt = 4'd7;
    tick(); chk_score("add7_1", 16'h0007);
    tick(); chk_score("add7_2", 16'h0014);
    tick(); chk_score("add7_3", 16'h0021);
    add_valid = 1'b0;
    chk_ovf("add7", 1'b0);
  endtask

  task automatic test_ripple();
    set_score(999);
    chk_score("load999", 16'h0999);
    add_valid = 1'b1; add_amt = 4'd5;
    tick(); chk_score("ripple", 16'h1004);
    add_amt = 4'd12;
    tick(); chk_score("clamp_add", 16'h1013);
    add_valid = 1'b0;
  endtask

  task automatic test_saturate();
    set_score(9995);
    chk_score("load9995", 16'h9995);
    add_valid = 1'b1; add_amt = 4'd9;
    tick(); chk_score("sat", 16'h9999); chk_ovf("sat", 1'b1);
    add_amt = 4'd1;
    tick(); chk_score("sat_again", 16'h9999); chk_ovf("sat_again", 1'b1);
    add_valid = 1'b0; sub_valid = 1'b1; sub_amt = 4'd1;
    tick(); chk_score("sub_keeps_ovf", 16'h9998); chk_ovf("sub_keeps_ovf", 1'b1);
    sub_valid = 1'b0; clear = 1'b1;
    tick(); chk_score("clear", 16'h0000); chk_ovf("clear", 1'b0);
    clear = 1'b0;
  endtask

  task automatic test_sub();
    set_score(3);
    sub_valid = 1'b1; sub_amt = 4'd8;
    tick(); chk_score("floor", 16'h0000); chk_ovf("floor", 1'b0);
    sub_valid = 1'b0;
    set_score(100);
    sub_valid = 1'b1; sub_amt = 4'd1;
    tick(); chk_score("borrow", 16'h0099);
    sub_amt = 4'd15;
    tick(); chk_score("clamp_sub", 16'h0090);
    add_valid = 1'b1; add_amt = 4'd4; sub_amt = 4'd2;
    tick(); chk_score("add_wins", 16'h0094);
    add_valid = 1'b0; sub_valid = 1'b0;
  endtask

  task automatic test_gating();
    gaming = 1'b0; add_valid = 1'b1; add_amt = 4'd5;
    tick(); chk_score("gated_add", 16'h0094);
    tick(); chk_score("gated_add2", 16'h0094);
    add_valid = 1'b0; sub_valid = 1'b1; sub_amt = 4'd3;
    tick(); chk_score("gated_sub", 16'h0094);
    sub_valid = 1'b0; clear = 1'b1;
    tick(); chk_score("idle_clear", 16'h0000);
    clear = 1'b0;
  endtask

  task automatic test_end_game();
    do_reset();
    set_score(250);
    chk_hi("in_game", 16'h0000, 1'b0);
    gaming = 1'b0;
    tick(); chk_hi("end1", 16'h0250, 1'b1);
    tick(); chk_hi("end1_after", 16'h0250, 1'b0);
    set_score(120);
    gaming = 1'b0;
    tick(); chk_hi("end2_lower", 16'h0250, 1'b0);
    set_score(300);
    gaming = 1'b0; clear = 1'b1;
    tick(); chk_hi("end3_clear", 16'h0300, 1'b1); chk_score("end3_clear", 16'h0000);
    clear = 1'b0;
    tick(); chk_hi("end3_after", 16'h0300, 1'b0);
  endtask

  task automatic test_async_reset();
    set_score(42);
    add_valid = 1'b1; add_amt = 4'd9;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_score("async_rst", 16'h0000);
    chk_ovf("async_rst", 1'b0);
    chk_hi("async_rst", 16'h0000, 1'b0);
    #1 rst = 1'b0;
    add_amt = 4'd5;
    tick(); chk_score("post_rst_add", 16'h0005);
    add_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    add_valid = 1'b1;
    add_amt = 4'd9; tick();
    add_amt = 4'd9; tick();
    add_valid = 1'b0; sub_valid = 1'b1; sub_amt = 4'd4; tick();
    sub_valid = 1'b0;
    chk_score("b2b", 16'h0019);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_saturate();
    test_sub();
    test_gating();
    test_end_game();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
